// File: rtl/lamp_request_arbiter.sv
// Indicator lamp arbiter: resolves hazard/ESS, stalk and comfort-tap requests
// onto the left/right lamps with a single phase-coherent blink generator.
module lamp_request_arbiter #(
  parameter int unsigned HALF_PERIOD     = 25_000_000,
  parameter int unsigned CNT_W           = 25,
  parameter int unsigned COMFORT_FLASHES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_hazard,
  input  logic       ess_active,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       tap_left,
  input  logic       tap_right,
  output logic       lamp_left,
  output logic       lamp_right,
  output logic       click,
  output logic [2:0] state_out
);

  localparam int unsigned FLASH_W = $clog2(COMFORT_FLASHES + 1);
  localparam logic [CNT_W-1:0]   PHASE_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(COMFORT_FLASHES - 1);
  localparam logic [FLASH_W-1:0] FLASH_MAX  = FLASH_W'(COMFORT_FLASHES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN_L = 3'd1,
    TURN_R = 3'd2,
    COMF_L = 3'd3,
    COMF_R = 3'd4,
    HAZARD = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic               phase_on_q, phase_on_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               lamp_left_d, lamp_right_d, click_d;

  logic haz, turn_l_ok, turn_r_ok, tap_l_ok, tap_r_ok;
  logic in_comf, wrap, on_fall;

  // State, phase and registered lamp outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      phase_on_q  <= 1'b0;
      flash_cnt_q <= '0;
      lamp_left   <= 1'b0;
      lamp_right  <= 1'b0;
      click       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      phase_on_q  <= phase_on_d;
      flash_cnt_q <= flash_cnt_d;
      lamp_left   <= lamp_left_d;
      lamp_right  <= lamp_right_d;
      click       <= click_d;
    end
  end

  // Request arbitration, phase sequencing and comfort counting
  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    phase_on_d   = phase_on_q;
    flash_cnt_d  = flash_cnt_q;
    lamp_left_d  = 1'b0;
    lamp_right_d = 1'b0;
    click_d      = 1'b0;

    haz       = sw_hazard | ess_active;
    turn_l_ok = turn_left & ~turn_right;
    turn_r_ok = turn_right & ~turn_left;
    tap_l_ok  = tap_left & ~tap_right;
    tap_r_ok  = tap_right & ~tap_left;
    in_comf   = (state_q == COMF_L) || (state_q == COMF_R);
    wrap      = (phase_cnt_q == PHASE_LAST);
    on_fall   = wrap & phase_on_q;

    if (haz) begin
      state_d = HAZARD;
    end else if (turn_l_ok) begin
      state_d = TURN_L;
    end else if (turn_r_ok) begin
      state_d = TURN_R;
    end else if ((tap_l_ok || tap_r_ok) && (state_q != HAZARD)) begin
      state_d     = tap_l_ok ? COMF_L : COMF_R;
      flash_cnt_d = '0;
    end else if (in_comf) begin
      if (on_fall) begin
        if (flash_cnt_q == FLASH_LAST) begin
          state_d = IDLE;
        end else if (flash_cnt_q != FLASH_MAX) begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
      end
    end else begin
      state_d = IDLE;
    end

    // Blink restarts only when leaving IDLE; active-to-active keeps the phase
    if (state_d == IDLE) begin
      phase_cnt_d = '0;
      phase_on_d  = 1'b0;
      flash_cnt_d = '0;
    end else if (state_q == IDLE) begin
      phase_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (wrap) begin
      phase_cnt_d = '0;
      phase_on_d  = ~phase_on_q;
    end else begin
      phase_cnt_d = phase_cnt_q + 1'b1;
    end

    lamp_left_d  = phase_on_d &
                   ((state_d == TURN_L) || (state_d == COMF_L) || (state_d == HAZARD));
    lamp_right_d = phase_on_d &
                   ((state_d == TURN_R) || (state_d == COMF_R) || (state_d == HAZARD));
    click_d      = ~(lamp_left | lamp_right) & (lamp_left_d | lamp_right_d);
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_lamp_request_arbiter.sv
// Directed self-checking bench for lamp_request_arbiter with a short blink
// period (HALF_PERIOD=4) so whole comfort sequences fit in a few dozen cycles.
module tb_lamp_request_arbiter;

  logic       clk;
  logic       rst;
  logic       sw_hazard, ess_active, turn_left, turn_right, tap_left, tap_right;
  logic       lamp_left, lamp_right, click;
  logic [2:0] state_out;

  int checks   = 0;
  int failures = 0;

  lamp_request_arbiter #(
    .HALF_PERIOD    (4),
    .CNT_W          (3),
    .COMFORT_FLASHES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_hazard (sw_hazard),
    .ess_active(ess_active),
    .turn_left (turn_left),
    .turn_right(turn_right),
    .tap_left  (tap_left),
    .tap_right (tap_right),
    .lamp_left (lamp_left),
    .lamp_right(lamp_right),
    .click     (click),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed view {lamp_left, lamp_right, click, state_out}
  function automatic logic [31:0] pack(input logic l, input logic r, input logic c,
                                       input logic [2:0] s);
    return {26'd0, l, r, c, s};
  endfunction

  function automatic logic [31:0] obs_v();
    return pack(lamp_left, lamp_right, click, state_out);
  endfunction

  // One comfort tap, then three ON halves (k 0-3, 8-11, 16-19) and IDLE from k=20
  task automatic run_comfort(input bit right, input string name);
    logic on;
    if (right) tap_right = 1'b1; else tap_left = 1'b1;
    @(negedge clk);
    tap_right = 1'b0;
    tap_left  = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k > 0) @(negedge clk);
      on = (k < 20) && ((k % 8) < 4);
      check($sformatf("%s_k%0d", name, k), obs_v(),
            pack(on & !right, on & right, on && ((k % 8) == 0),
                 (k < 20) ? (right ? 3'd4 : 3'd3) : 3'd0));
    end
  endtask

  initial begin
    logic on;
    rst = 1'b0;
    {sw_hazard, ess_active, turn_left, turn_right, tap_left, tap_right} = '0;
    repeat (3) @(negedge clk);
    check("reset_state", obs_v(), pack(0, 0, 0, 3'd0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs_v(), pack(0, 0, 0, 3'd0));

    // Held left stalk: 4 on / 4 off, click at each ON start
    turn_left = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      on = (k % 8) < 4;
      check($sformatf("turn_l_k%0d", k), obs_v(), pack(on, 0, (k % 8) == 0, 3'd1));
    end
    turn_left = 1'b0;
    @(negedge clk);
    check("turn_release_idle", obs_v(), pack(0, 0, 0, 3'd0));

    run_comfort(1'b1, "comf_r");

    // Right stalk, hazard joins mid-ON-half without resetting the phase
    turn_right = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      on = (k % 8) < 4;
      if (k < 2)
        check($sformatf("haz_pre_k%0d", k), obs_v(), pack(0, on, k == 0, 3'd2));
      else if (k < 10)
        check($sformatf("haz_k%0d", k), obs_v(), pack(on, on, k == 8, 3'd5));
      else if (k == 10)
        check("haz_drop_turn_r", obs_v(), pack(0, 1, 0, 3'd2));
      else
        check("haz_turn_idle", obs_v(), pack(0, 0, 0, 3'd0));
      if (k == 1) sw_hazard = 1'b1;
      if (k == 9) sw_hazard = 1'b0;
      if (k == 10) turn_right = 1'b0;
    end

    // ESS preempts comfort left for 20 cycles; comfort is not resumed
    tap_left = 1'b1;
    @(negedge clk);
    tap_left = 1'b0;
    check("ess_comf_start", obs_v(), pack(1, 0, 1, 3'd3));
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      on = (k % 8) < 4;
      if (k == 1)
        check("ess_comf_k1", obs_v(), pack(1, 0, 0, 3'd3));
      else if (k < 22)
        check($sformatf("ess_haz_k%0d", k), obs_v(), pack(on, on, (k % 8) == 0, 3'd5));
      else
        check($sformatf("ess_idle_k%0d", k), obs_v(), pack(0, 0, 0, 3'd0));
      if (k == 1) ess_active = 1'b1;
      if (k == 21) ess_active = 1'b0;
    end

    // Conflicting stalk levels are ignored until one is released
    turn_left  = 1'b1;
    turn_right = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("both_turn_k%0d", k), obs_v(), pack(0, 0, 0, 3'd0));
    end
    turn_right = 1'b0;
    @(negedge clk);
    check("both_drop_r", obs_v(), pack(1, 0, 1, 3'd1));
    turn_left = 1'b0;
    @(negedge clk);
    check("both_release", obs_v(), pack(0, 0, 0, 3'd0));

    // Async reset during an ON half
    tap_left = 1'b1;
    @(negedge clk);
    tap_left = 1'b0;
    check("rst_pre_k0", obs_v(), pack(1, 0, 1, 3'd3));
    @(negedge clk);
    check("rst_pre_k1", obs_v(), pack(1, 0, 0, 3'd3));
    #2 rst = 1'b0;
    #1 check("rst_async", obs_v(), pack(0, 0, 0, 3'd0));
    @(negedge clk);
    check("rst_held", obs_v(), pack(0, 0, 0, 3'd0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_released_idle", obs_v(), pack(0, 0, 0, 3'd0));
    run_comfort(1'b1, "post_rst_comf");

    // Simultaneous taps are ignored
    tap_left  = 1'b1;
    tap_right = 1'b1;
    @(negedge clk);
    tap_left  = 1'b0;
    tap_right = 1'b0;
    check("both_taps", obs_v(), pack(0, 0, 0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
